// File: rtl/enum_level_walker.sv
// enum_level_walker: steps through level_e (0,10,20,30,40) via first/last/next/prev/load commands
module enum_level_walker #(
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_step,
  input  logic [31:0]       cmd_raw,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_level,
  output logic [2:0]        rsp_index,
  output logic              rsp_err,
  output logic [31:0]       num_vals_out
);
  typedef enum logic [1:0] {IDLE, WALK, RESP} state_t;
  state_t state, state_n;
  logic [2:0] idx, idx_n, inc, dec, load_idx;
  logic [STEP_W-1:0] rem, rem_n;
  logic err, err_n, dir, dir_n, load_ok, accept;
  assign num_vals_out = 32'd5;
  assign cmd_ready = state == IDLE;
  assign rsp_valid = state == RESP;
  assign rsp_index = idx;
  assign rsp_level = 32'(idx) * 32'd10;
  assign rsp_err = err;
  assign accept = cmd_valid & cmd_ready;
  assign inc = idx == 3'd4 ? 3'd0 : idx + 3'd1;
  assign dec = idx == 3'd0 ? 3'd4 : idx - 3'd1;
  assign load_ok = cmd_raw == 32'd0 || cmd_raw == 32'd10 || cmd_raw == 32'd20 ||
                   cmd_raw == 32'd30 || cmd_raw == 32'd40;
  assign load_idx = cmd_raw == 32'd10 ? 3'd1 : cmd_raw == 32'd20 ? 3'd2 :
                    cmd_raw == 32'd30 ? 3'd3 : cmd_raw == 32'd40 ? 3'd4 : 3'd0;
  // state, current level index, error flag and walk bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      idx   <= 3'd0;
      err   <= 1'b0;
      dir   <= 1'b0;
      rem   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      err   <= err_n;
      dir   <= dir_n;
      rem   <= rem_n;
    end
  end
  // command decode, one-position-per-cycle walk, and response hold
  always_comb begin
    state_n = state;
    idx_n   = idx;
    err_n   = err;
    dir_n   = dir;
    rem_n   = rem;
    case (state)
      IDLE: if (accept) begin
        state_n = RESP;
        err_n   = 1'b0;
        case (cmd_op)
          3'd0: idx_n = 3'd0;
          3'd1: idx_n = 3'd4;
          3'd2, 3'd3: if (cmd_step != '0) begin
            state_n = WALK;
            dir_n   = cmd_op == 3'd3;
            rem_n   = cmd_step;
          end
          3'd4: begin
            idx_n = load_ok ? load_idx : idx;
            err_n = !load_ok;
          end
          default: err_n = 1'b1;
        endcase
      end
      WALK: begin
        idx_n   = dir ? dec : inc;
        rem_n   = rem - 1'b1;
        state_n = rem == 1 ? RESP : WALK;
      end
      RESP: state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_enum_level_walker.sv
// tb_enum_level_walker: scoreboard bench for enum_level_walker with directed vectors
module tb_enum_level_walker;
  logic clk = 0, rst = 1, cmd_valid = 0, rsp_ready = 1;
  logic cmd_ready, rsp_valid, rsp_err;
  logic [2:0] cmd_op = 0, rsp_index;
  logic [7:0] cmd_step = 0;
  logic [31:0] cmd_raw = 0, rsp_level, num_vals_out;
  typedef struct { int level; int index; bit err; int lat; } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0, acc = 0;
  bit was_valid = 0;

  enum_level_walker dut (.clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_step(cmd_step), .cmd_raw(cmd_raw), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_level(rsp_level), .rsp_index(rsp_index), .rsp_err(rsp_err),
    .num_vals_out(num_vals_out));

  always #5 clk = ~clk;

  task automatic chk(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (cmd_valid && cmd_ready && !rst) acc = cyc;
    if (rsp_valid && !was_valid) begin
      if (q.size() == 0) chk("unexpected_rsp", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_level", int'(rsp_level), e.level);
        chk("rsp_index", int'(rsp_index), e.index);
        chk("rsp_err", int'(rsp_err), int'(e.err));
        chk("latency", cyc - acc, e.lat);
        chk("num_vals", int'(num_vals_out), 5);
      end
    end
    was_valid = rsp_valid;
  end

  task automatic issue(int op, int step, int raw, int el, int ei, bit ee, int lat, bit push);
    int n = 0;
    if (push) q.push_back('{el, ei, ee, lat});
    cmd_valid = 1; cmd_op = 3'(op); cmd_step = 8'(step); cmd_raw = 32'(raw);
    while (!cmd_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n == 50) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    cmd_valid = 0; cmd_op = 3'd5; cmd_raw = 32'hdead;
    chk("cmd_ready_after_accept", int'(cmd_ready), 0);
  endtask

  task automatic wait_hs();
    int n = 0;
    while (!(rsp_valid && rsp_ready) && n < 300) begin @(posedge clk); #1; n++; end
    if (n == 300) chk("rsp_timeout", 0, 1);
    else begin @(posedge clk); #1; end
  endtask

  task automatic send(int op, int step, int raw, int el, int ei, bit ee, int lat);
    issue(op, step, raw, el, ei, ee, lat, 1);
    wait_hs();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    chk("num_vals_in_reset", int'(num_vals_out), 5);
    #1 rst = 0;
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_cmd_ready", int'(cmd_ready), 1);
    chk("reset_err", int'(rsp_err), 0);
    chk("reset_level", int'(rsp_level), 0);
    chk("reset_index", int'(rsp_index), 0);
    send(0, 0, 0, 0, 0, 0, 1);
    send(4, 0, 20, 20, 2, 0, 1);
    send(4, 0, 25, 20, 2, 1, 1);
    send(4, 0, -10, 20, 2, 1, 1);
    send(2, 3, 0, 0, 0, 0, 4);
    send(4, 0, 10, 10, 1, 0, 1);
    send(3, 7, 0, 40, 4, 0, 8);
    send(1, 0, 0, 40, 4, 0, 1);
    send(2, 1, 0, 0, 0, 0, 2);
    send(2, 0, 0, 0, 0, 0, 1);
    send(3, 1, 0, 40, 4, 0, 2);
    send(7, 0, 0, 40, 4, 1, 1);
    chk("err_retained", int'(rsp_err), 1);
    rsp_ready = 0;
    issue(4, 0, 30, 30, 3, 0, 1, 1);
    chk("bp_valid_rise", int'(rsp_valid), 1);
    cmd_valid = 1; cmd_op = 3'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", int'(rsp_valid), 1);
      chk("bp_level", int'(rsp_level), 30);
      chk("bp_err", int'(rsp_err), 0);
      chk("bp_cmd_ready", int'(cmd_ready), 0);
    end
    cmd_valid = 0; rsp_ready = 1;
    @(posedge clk); #1;
    chk("bp_after_hs_ready", int'(cmd_ready), 1);
    chk("bp_after_hs_valid", int'(rsp_valid), 0);
    issue(2, 200, 0, 0, 0, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    chk("rst_walk_level", int'(rsp_level), 0);
    chk("rst_walk_valid", int'(rsp_valid), 0);
    chk("rst_walk_ready", int'(cmd_ready), 1);
    chk("rst_walk_err", int'(rsp_err), 0);
    send(6, 0, 0, 0, 0, 1, 1);
    repeat (3) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/enum_level_walker.md
Name: enum_level_walker

Overview:
- Iterates over the `level_e` enumeration from `enum_types`: E_NONE=0, E_LOW=10, E_MEDIUM=20, E_HIGH=30, E_MAX=40.
- Complements the `num()` query with the other enum methods: `first()`, `last()`, `next(N)`, `prev(N)`, plus a checked cast from a raw int.
- Commands arrive on a valid/ready handshake; results leave on a valid/ready handshake.
- Used by test sequencers and config logic that step through severity levels.

Parameters:
- STEP_W, 8, width of the step count for NEXT/PREV.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_op  input  3  0=FIRST, 1=LAST, 2=NEXT, 3=PREV, 4=LOAD, 5-7 illegal
- cmd_step  input  STEP_W  N for NEXT/PREV, unsigned
- cmd_raw  input  32  raw int for LOAD
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts result
- rsp_level  output  32  current level as int (`level_e` value)
- rsp_index  output  3  ordinal position of current level, 0..4
- rsp_err  output  1  last command illegal, or LOAD value is not a member
- num_vals_out  output  32  constant 5 (`level_e.num()`)

Behaviour:
- Reset is synchronous and active-high. Clock `clk`, reset `rst`.
- Reset values:
  - state IDLE; current level E_NONE, index 0
  - rsp_valid=0, rsp_err=0, cmd_ready=1
  - num_vals_out=5 at all times, including during reset.
- rsp_level and rsp_index are registered and always reflect the current level. They are only meaningful when rsp_valid=1.
- FSM states: IDLE, WALK, RESP.
- IDLE:
  - cmd_ready=1; a command is accepted when cmd_valid & cmd_ready.
  - FIRST: level=E_NONE, err=0, go to RESP.
  - LAST: level=E_MAX, err=0, go to RESP.
  - LOAD:
    - cmd_raw in {0,10,20,30,40}: level=member, err=0.
    - Any other value, including negatives: level unchanged, err=1.
    - Go to RESP.
  - NEXT/PREV with cmd_step=0: level unchanged, err=0, go to RESP.
  - NEXT/PREV with cmd_step>0: latch direction, load remaining=cmd_step, err=0, go to WALK.
  - Ops 5-7: level unchanged, err=1, go to RESP.
- WALK:
  - cmd_ready=0.
  - Each cycle, move exactly one position in the latched direction and decrement remaining.
  - Wrap-around: E_MAX.next = E_NONE; E_NONE.prev = E_MAX.
  - Go to RESP in the cycle the last step is applied (remaining 1→0).
- RESP:
  - cmd_ready=0, rsp_valid=1.
  - rsp_level, rsp_index and rsp_err are held stable until rsp_ready=1.
  - On the handshake, go to IDLE; rsp_valid drops the next cycle.
- Latency from the accept edge to rsp_valid:
  - 1 cycle for FIRST, LAST, LOAD, illegal ops, and step=0.
  - cmd_step+1 cycles for NEXT/PREV with step>0.
- Throughput: at most one command per 2 cycles. A new command cannot be accepted in the same cycle as the response handshake.
- rsp_err is updated only when a command is accepted; it keeps its value after the response until the next command.
- cmd_* inputs are sampled only on accept; changes during WALK or RESP are ignored.
- rst asserted in any state, mid-walk included:
  - next cycle: IDLE, level E_NONE, rsp_valid=0, rsp_err=0, cmd_ready=1;
  - any pending walk or response is discarded.
- Index arithmetic: mod 5. Steps larger than 5 wrap repeatedly, e.g. step 255 = 255 mod 5 = 0 net positions, but still takes 255 walk cycles.

Test Plan:
- Reset, then FIRST with rsp_ready=1 → rsp_valid 1 cycle after accept; level 0, index 0, err 0; num_vals_out=5 throughout.
- LOAD 20 → level 20, index 2, err 0. Then LOAD 25 → err 1, level stays 20. Then LOAD -10 → err 1.
- From E_MEDIUM, NEXT step 3 → walk 20→30→40→0. rsp_valid 4 cycles after accept; level 0, index 0; cmd_ready low for those 4 cycles.
- From E_LOW, PREV step 7 → level 40, index 4, rsp_valid 8 cycles after accept. Then LAST followed by NEXT step 1 → level 0.
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_valid, level and err stable, cmd_ready=0, cmd_valid ignored. Raise rsp_ready → handshake; cmd_ready=1 the cycle after.
- Assert rst for 1 cycle during a NEXT step 200 walk → next cycle level 0, rsp_valid 0, cmd_ready 1. An illegal op 6 afterwards → err 1, level 0.
